tiny_nn_conv_seq: RTL and testbench

// Host-side sequencer for the tiny_nn convolve flow. Holds 8 convolve parameters and streams the

---
 rtl/tiny_nn_conv_seq.sv | 149 ++++++++++++++
 tb/tb_tiny_nn_conv_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_nn_conv_seq.sv
// Host-side sequencer for the tiny_nn convolve flow: streams command, parameters, values,
// terminator and flush words to the core and reassembles its result bytes into 16-bit words.
module tiny_nn_conv_seq #(
  parameter int unsigned FlushCycles   = 5,
  parameter int unsigned ResultSkip    = 2,
  parameter logic [15:0] IdleWord      = 16'h0000,
  parameter logic [3:0]  CmdOpConvolve = 4'h3,
  parameter logic [15:0] FPStdNaN      = 16'h7E00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        param_we_i,
  input  logic [2:0]  param_idx_i,
  input  logic [15:0] param_wdata_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] val_i,
  input  logic        val_valid_i,
  input  logic        val_last_i,
  output logic        val_ready_o,
  output logic [15:0] nn_data_o,
  input  logic [7:0]  nn_data_i,
  output logic        nn_rst_no,
  output logic [15:0] res_o,
  output logic        res_valid_o,
  output logic        busy_o,
  output logic        underrun_o,
  output logic        nan_sub_o
);

  // The 4x2 value array fixes the parameter count at 8, matching the 3-bit index.
  localparam int unsigned NumParams = 8;
  localparam logic [2:0]  ParamLast = 3'(NumParams - 1);
  localparam logic [2:0]  FlushLoad = 3'(FlushCycles - 1);
  localparam logic [1:0]  SkipPairs = 2'(ResultSkip);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_PARAM, S_EXEC, S_TERM, S_FLUSH
  } state_t;

  state_t      state, state_next;
  logic [15:0] params [NumParams];
  logic [2:0]  pidx;
  logic [2:0]  flush_cnt;
  logic        abort_q;
  logic        k_odd;
  logic [1:0]  pair_cnt;
  logic [7:0]  low_byte;
  logic [15:0] res_q;
  logic        res_valid_q;
  logic        underrun_q;
  logic        nan_q;
  logic [15:0] nn_data;
  logic        val_ready;
  logic        window;

  always_comb begin
    state_next = state;
    nn_data    = IdleWord;
    val_ready  = 1'b0;
    case (state)
      S_IDLE:  if (start_i) state_next = S_CMD;
      S_CMD: begin
        nn_data    = {CmdOpConvolve, 12'h000};
        state_next = S_PARAM;
      end
      S_PARAM: begin
        nn_data = params[pidx];
        if (pidx == ParamLast) state_next = S_EXEC;
      end
      S_EXEC: begin
        val_ready = 1'b1;
        // Starved or NaN-valued slots become zero so the core never sees an early terminator.
        nn_data   = (val_valid_i && (val_i != FPStdNaN)) ? val_i : 16'h0000;
        if (val_valid_i && val_last_i) state_next = S_TERM;
      end
      S_TERM: begin
        nn_data    = FPStdNaN;
        state_next = S_FLUSH;
      end
      S_FLUSH: if (flush_cnt == 3'd0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_i) begin
      state_next = S_IDLE;
      nn_data    = IdleWord;
      val_ready  = 1'b0;
    end
  end

  assign window = (state == S_EXEC) || (state == S_TERM) || (state == S_FLUSH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      pidx        <= 3'd0;
      flush_cnt   <= 3'd0;
      abort_q     <= 1'b0;
      k_odd       <= 1'b0;
      pair_cnt    <= 2'd0;
      low_byte    <= 8'h00;
      res_q       <= 16'h0000;
      res_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      nan_q       <= 1'b0;
      for (int i = 0; i < NumParams; i++) params[i] <= 16'h0000;
    end else begin
      state       <= state_next;
      abort_q     <= abort_i;
      res_valid_q <= 1'b0;
      if ((state == S_IDLE) && param_we_i) params[param_idx_i] <= param_wdata_i;
      pidx <= (state == S_PARAM) ? pidx + 3'd1 : 3'd0;
      if (state == S_TERM)                         flush_cnt <= FlushLoad;
      else if (state == S_FLUSH && flush_cnt != 0) flush_cnt <= flush_cnt - 3'd1;
      // Even window slots hold the low byte; odd slots complete a pair.
      if (window && !abort_i) begin
        k_odd <= ~k_odd;
        if (!k_odd) begin
          low_byte <= nn_data_i;
        end else if (pair_cnt == SkipPairs) begin
          res_q       <= {nn_data_i, low_byte};
          res_valid_q <= 1'b1;
        end else begin
          pair_cnt <= pair_cnt + 2'd1;
        end
      end else begin
        k_odd    <= 1'b0;
        pair_cnt <= 2'd0;
      end
      if (abort_i || (state == S_IDLE && start_i)) begin
        underrun_q <= 1'b0;
        nan_q      <= 1'b0;
      end else if (state == S_EXEC) begin
        if (!val_valid_i)               underrun_q <= 1'b1;
        if (val_valid_i && val_i == FPStdNaN) nan_q <= 1'b1;
      end
    end
  end

  assign nn_data_o   = nn_data;
  assign val_ready_o = val_ready;
  assign nn_rst_no   = ~(rst_i | abort_q);
  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = (state != S_IDLE);
  assign underrun_o  = underrun_q;
  assign nan_sub_o   = nan_q;

endmodule

// File: tb/tb_tiny_nn_conv_seq.sv
// Bench for tiny_nn_conv_seq: table-driven and random convolve runs checked against a
// stream-level model, plus hand sequences for reset and abort.
module tb_tiny_nn_conv_seq;

  localparam logic [15:0] CMD_WORD = 16'h3000;
  localparam logic [15:0] NAN_WORD = 16'h7E00;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        param_we_i = 1'b0;
  logic [2:0]  param_idx_i = 3'd0;
  logic [15:0] param_wdata_i = 16'h0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] val_i = 16'h0;
  logic        val_valid_i = 1'b0;
  logic        val_last_i = 1'b0;
  logic        val_ready_o;
  logic [15:0] nn_data_o;
  logic [7:0]  nn_data_i = 8'h0;
  logic        nn_rst_no;
  logic [15:0] res_o;
  logic        res_valid_o;
  logic        busy_o;
  logic        underrun_o;
  logic        nan_sub_o;

  int total = 0;
  int bad = 0;
  logic [15:0] pm [8];

  tiny_nn_conv_seq dut (
    .clk_i(clk), .rst_i(rst_i), .param_we_i(param_we_i), .param_idx_i(param_idx_i),
    .param_wdata_i(param_wdata_i), .start_i(start_i), .abort_i(abort_i), .val_i(val_i),
    .val_valid_i(val_valid_i), .val_last_i(val_last_i), .val_ready_o(val_ready_o),
    .nn_data_o(nn_data_o), .nn_data_i(nn_data_i), .nn_rst_no(nn_rst_no), .res_o(res_o),
    .res_valid_o(res_valid_o), .busy_o(busy_o), .underrun_o(underrun_o), .nan_sub_o(nan_sub_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nvals; int ngap; int nan_at;
    int exp_busy; int exp_pulses; bit exp_under; bit exp_nan;
  } row_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full convolve: the model is the expected word stream plus byte-pair folding.
  task automatic run_conv(input int nvals, input int ngap, input int nan_at, input bit wr_start,
                          output int busy_cnt, output int pulses, output bit under, output bit nanf);
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [7:0]  bytes[$];
    bit          ex_v[$];
    logic [15:0] ex_d[$];
    bit          ex_l[$];
    bit          e_under = 0, e_nan = 0;
    int          gap_pos = (nvals > 1) ? 1 : 0;
    int          E, L;
    logic [15:0] d;
    for (int i = 0; i < nvals; i++) begin
      if (i == gap_pos)
        for (int g = 0; g < ngap; g++) begin
          ex_v.push_back(0); ex_d.push_back(16'($urandom)); ex_l.push_back(1'($urandom));
          e_under = 1;
        end
      d = 16'($urandom);
      if (d == NAN_WORD) d ^= 16'h1;
      if (i == nan_at) begin d = NAN_WORD; e_nan = 1; end
      ex_v.push_back(1); ex_d.push_back(d); ex_l.push_back(i == nvals - 1);
    end
    E = ex_v.size();
    start_i = 1'b1;
    param_we_i = wr_start;
    param_idx_i = 3'($urandom);
    param_wdata_i = 16'($urandom);
    if (wr_start) pm[param_idx_i] = param_wdata_i;
    exp_q.push_back(CMD_WORD);
    for (int i = 0; i < 8; i++) exp_q.push_back(pm[i]);
    for (int i = 0; i < E; i++)
      exp_q.push_back((ex_v[i] && ex_d[i] != NAN_WORD) ? ex_d[i] : 16'h0000);
    exp_q.push_back(NAN_WORD);
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0000);
    L = exp_q.size();
    @(negedge clk);
    check("busy_before_start", busy_o, 0);
    tick();
    busy_cnt = 0;
    for (int c = 0; c < L + 3; c++) begin
      start_i = (c < L) ? 1'($urandom) : 1'b0;
      param_we_i = (c < L) ? 1'($urandom) : 1'b0;
      param_idx_i = 3'($urandom);
      param_wdata_i = 16'($urandom);
      nn_data_i = 8'($urandom);
      if (c >= 9 && c < 9 + E) begin
        val_valid_i = ex_v[c-9]; val_i = ex_d[c-9]; val_last_i = ex_l[c-9];
      end else begin
        val_valid_i = 1'($urandom); val_i = 16'($urandom); val_last_i = 1'($urandom);
      end
      @(negedge clk);
      if (busy_o) busy_cnt++;
      check("nn_data", nn_data_o, (c < L) ? exp_q[c] : 16'h0000);
      check("busy", busy_o, c < L);
      check("val_ready", val_ready_o, c >= 9 && c < 9 + E);
      if (c == 0) begin
        check("underrun_clear", underrun_o, 0);
        check("nan_clear", nan_sub_o, 0);
      end
      if (c >= 9 && c < L) bytes.push_back(nn_data_i);
      if (res_valid_o) got_q.push_back(res_o);
      tick();
    end
    check("underrun_sticky", underrun_o, e_under);
    check("nan_sticky", nan_sub_o, e_nan);
    check("pulse_count", got_q.size(), bytes.size() / 2 - 2);
    for (int j = 2; j < bytes.size() / 2; j++)
      if (j - 2 < got_q.size())
        check("res_word", got_q[j-2], {bytes[2*j+1], bytes[2*j]});
    pulses = got_q.size();
    under = underrun_o;
    nanf = nan_sub_o;
  endtask

  initial begin
    row_t rows[5];
    int bc, pc, nv, ng, na;
    bit uf, nf;
    rows[0] = '{4, 0, -1, 19, 3, 0, 0};
    rows[1] = '{1, 0, -1, 16, 1, 0, 0};
    rows[2] = '{3, 2, -1, 20, 3, 1, 0};
    rows[3] = '{2, 0,  1, 17, 2, 0, 1};
    rows[4] = '{6, 1,  0, 22, 4, 1, 1};

    @(posedge clk);
    @(negedge clk);
    check("rst_nn_rst_no", nn_rst_no, 0);
    check("rst_nn_data", nn_data_o, 16'h0000);
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_nn_rst_no", nn_rst_no, 1);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_flags", {underrun_o, nan_sub_o, res_valid_o, val_ready_o}, 4'b0);
    tick();

    for (int i = 0; i < 8; i++) begin
      param_we_i = 1'b1; param_idx_i = 3'(i); param_wdata_i = 16'h3C00 + 16'(i);
      pm[i] = param_wdata_i;
      tick();
    end
    param_we_i = 1'b0;

    for (int r = 0; r < 5; r++) begin
      run_conv(rows[r].nvals, rows[r].ngap, rows[r].nan_at, r != 0, bc, pc, uf, nf);
      check("row_busy_cycles", bc, rows[r].exp_busy);
      check("row_pulses", pc, rows[r].exp_pulses);
      check("row_underrun", uf, rows[r].exp_under);
      check("row_nan", nf, rows[r].exp_nan);
    end

    for (int r = 0; r < 20; r++) begin
      nv = $urandom_range(1, 8);
      ng = $urandom_range(0, 3);
      na = $urandom_range(0, nv);
      if (na == nv) na = -1;
      run_conv(nv, ng, na, 1'b1, bc, pc, uf, nf);
    end

    // Abort in Param with a simultaneous start.
    start_i = 1'b1; tick(); start_i = 1'b0;
    tick(); tick(); tick();
    abort_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    check("abort_cycle_busy", busy_o, 1);
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("abort_idle", busy_o, 0);
    check("abort_core_rst", nn_rst_no, 0);
    check("abort_nn_data", nn_data_o, 16'h0000);
    tick();
    @(negedge clk);
    check("abort_core_rst_release", nn_rst_no, 1);
    check("abort_still_idle", busy_o, 0);
    tick();

    // Abort in Exec after an underrun: the sticky flag clears.
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    val_valid_i = 1'b0;
    tick();
    abort_i = 1'b1;
    @(negedge clk);
    check("exec_underrun_set", underrun_o, 1);
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    check("exec_abort_flag_clear", underrun_o, 0);
    check("exec_abort_idle", busy_o, 0);
    check("exec_abort_ready", val_ready_o, 0);
    tick();

    // Abort and start together in Idle: start is ignored.
    abort_i = 1'b1; start_i = 1'b1;
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("idle_abort_start_ignored", busy_o, 0);
    check("idle_abort_core_rst", nn_rst_no, 0);
    tick();

    // Parameters survive abort: a clean run still sends the model's parameters.
    run_conv(4, 0, -1, 1'b0, bc, pc, uf, nf);
    check("after_abort_busy", bc, 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
